// File: rtl/matmul_accumulator_drain_pkg.sv
// Package for the accumulator/drain block.
// Holds the FSM state encoding and width helpers shared by the top, the
// row-select sub-module and the bus interface.
// Optional build macro used by this block: SWIRL_ACC_DRAIN_RELU_EN
// (ReLU clamp on the drained rows only).
package swirl_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } acc_state_e;

  // Accumulator element width: four times the operand precision.
  function automatic int acc_w(input int p);
    return 4 * p;
  endfunction

  // Index width that never collapses to zero bits (M = 1 still gets 1 bit).
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_accumulator_drain_if.sv
// Bus interface for matmul_accumulator_drain.
// Groups the job control, the tile input stream from the MMA array, the C
// operand feedback, the drained-row output stream and status/debug signals.
//   start_i, num_ktiles_i : job start and K-tile count (sampled in IDLE)
//   d_i, d_valid_i, d_ready_o : result tile stream from the array
//   c_o : accumulator fed back as the array's C operand
//   row_o, row_idx_o, row_valid_o, row_ready_i : drained row stream
//   busy_o, done_o : status; state_o : FSM state for checkers
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both high; the producer holds data stable while
// valid is high and ready is low, and ready never depends on valid.
// Modports: slave = this block, master = the environment driving it.
interface matmul_accumulator_drain_if
  import swirl_acc_pkg::*;
#(
  parameter int M    = 2,
  parameter int N    = 2,
  parameter int P    = 8,
  parameter int KT_W = 8
);
  localparam int ACC_W = acc_w(P);
  localparam int IW    = clog2_min1(M);

  logic                            start_i;
  logic [KT_W-1:0]                 num_ktiles_i;
  logic [M-1:0][N-1:0][ACC_W-1:0]  d_i;
  logic                            d_valid_i;
  logic                            d_ready_o;
  logic [M-1:0][N-1:0][ACC_W-1:0]  c_o;
  logic [N-1:0][ACC_W-1:0]         row_o;
  logic [IW-1:0]                   row_idx_o;
  logic                            row_valid_o;
  logic                            row_ready_i;
  logic                            busy_o;
  logic                            done_o;
  logic [1:0]                      state_o;

  modport slave (
    input  start_i, num_ktiles_i, d_i, d_valid_i, row_ready_i,
    output d_ready_o, c_o, row_o, row_idx_o, row_valid_o, busy_o, done_o,
           state_o
  );

  modport master (
    output start_i, num_ktiles_i, d_i, d_valid_i, row_ready_i,
    input  d_ready_o, c_o, row_o, row_idx_o, row_valid_o, busy_o, done_o,
           state_o
  );

endinterface

// File: rtl/matmul_accumulator_drain_acc_row_select.sv
// acc_row_select: combinational row mux from the accumulator to the drain
// stream, with an optional ReLU clamp (macro SWIRL_ACC_DRAIN_RELU_EN).
//   acc     : full M x N accumulator
//   row_sel : row index to present
//   row     : selected row (clamped when the macro is defined)
module acc_row_select
  import swirl_acc_pkg::*;
#(
  parameter int M     = 2,
  parameter int N     = 2,
  parameter int ACC_W = 32,
  parameter int IW    = 1
) (
  input  logic [M-1:0][N-1:0][ACC_W-1:0] acc,
  input  logic [IW-1:0]                  row_sel,
  output logic [N-1:0][ACC_W-1:0]        row
);

  logic [N-1:0][ACC_W-1:0] sel_row;

  // Compare-and-select loop keeps the mux in range even when M is not a
  // power of two.
  always_comb begin
    sel_row = '0;
    for (int r = 0; r < M; r++) begin
      if (row_sel == IW'(r)) sel_row = acc[r];
    end
  end

`ifdef SWIRL_ACC_DRAIN_RELU_EN
  // Negative elements (sign bit set) are replaced by zero on the way out.
  always_comb begin
    row = '0;
    for (int c = 0; c < N; c++) begin
      row[c] = sel_row[c][ACC_W-1] ? '0 : sel_row[c];
    end
  end
`else
  assign row = sel_row;
`endif

endmodule

// File: rtl/matmul_accumulator_drain.sv
// matmul_accumulator_drain: holds the running M x N accumulator across a job
// of K-tiles, feeds it back to the MMA array as C, then drains it one row per
// cycle on a valid/ready stream.
// Ports:
//   clk_i  : clock
//   rst_ni : synchronous active-low reset
//   bus    : matmul_accumulator_drain_if.slave (job control, tile stream,
//            C feedback, row stream, status, state_o debug)
// Optional macro: SWIRL_ACC_DRAIN_RELU_EN clamps negative drained elements
// to zero; the accumulator and c_o are never clamped.
module matmul_accumulator_drain
  import swirl_acc_pkg::*;
#(
  parameter int M    = 2,
  parameter int N    = 2,
  parameter int P    = 8,
  parameter int KT_W = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  matmul_accumulator_drain_if.slave    bus
);

  localparam int ACC_W = acc_w(P);
  localparam int IW    = clog2_min1(M);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ACCUM = ACCUM;
  localparam logic [1:0] S_DRAIN = DRAIN;

  logic [1:0]                     state_q;
  logic [M-1:0][N-1:0][ACC_W-1:0] acc_q;
  logic [KT_W-1:0]                ktiles_q;
  logic [KT_W-1:0]                tile_cnt_q;
  logic [IW-1:0]                  row_cnt_q;
  logic                           done_q;
  logic [N-1:0][ACC_W-1:0]        row_w;

  logic d_fire;
  logic row_fire;

  assign d_fire   = (state_q == S_ACCUM) && bus.d_valid_i;
  assign row_fire = (state_q == S_DRAIN) && bus.row_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      ktiles_q   <= '0;
      tile_cnt_q <= '0;
      row_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            // A zero count runs as a single tile.
            ktiles_q   <= (bus.num_ktiles_i == '0) ? KT_W'(1) : bus.num_ktiles_i;
            acc_q      <= '0;
            tile_cnt_q <= '0;
            state_q    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (d_fire) begin
            // The array already added C, so the tile is loaded as-is.
            acc_q      <= bus.d_i;
            tile_cnt_q <= tile_cnt_q + KT_W'(1);
            if (tile_cnt_q == ktiles_q - KT_W'(1)) begin
              row_cnt_q <= '0;
              state_q   <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (row_fire) begin
            if (row_cnt_q == IW'(M - 1)) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              row_cnt_q <= row_cnt_q + IW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  acc_row_select #(
    .M     (M),
    .N     (N),
    .ACC_W (ACC_W),
    .IW    (IW)
  ) u_row_select (
    .acc     (acc_q),
    .row_sel (row_cnt_q),
    .row     (row_w)
  );

  assign bus.d_ready_o   = (state_q == S_ACCUM);
  assign bus.row_valid_o = (state_q == S_DRAIN);
  assign bus.row_o       = row_w;
  assign bus.row_idx_o   = row_cnt_q;
  assign bus.c_o         = acc_q;
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.done_o      = done_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_matmul_accumulator_drain.sv
// Directed bench for matmul_accumulator_drain (M=N=2, P=8).
module tb_matmul_accumulator_drain;
  import swirl_acc_pkg::*;

  localparam int M    = 2;
  localparam int N    = 2;
  localparam int P    = 8;
  localparam int KT_W = 8;

  typedef logic [M-1:0][N-1:0][31:0] tile_t;
  typedef logic [N-1:0][31:0]        row_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  matmul_accumulator_drain_if #(.M(M), .N(N), .P(P), .KT_W(KT_W)) bus ();

  matmul_accumulator_drain #(.M(M), .N(N), .P(P), .KT_W(KT_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic tile_t tile(input int a, input int b, input int c, input int d);
    tile_t t;
    t[0][0] = 32'(a); t[0][1] = 32'(b);
    t[1][0] = 32'(c); t[1][1] = 32'(d);
    return t;
  endfunction

  function automatic row_t row2(input int a, input int b);
    row_t r;
    r[0] = 32'(a); r[1] = 32'(b);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.start_i      = 1'b0;
    bus.num_ktiles_i = '0;
    bus.d_i          = '0;
    bus.d_valid_i    = 1'b0;
    bus.row_ready_i  = 1'b0;
    n_cmp = 0;
    n_err = 0;

    // reset state
    tick(); tick();
    check("rst_busy",  128'(bus.busy_o), 128'(0));
    check("rst_dready", 128'(bus.d_ready_o), 128'(0));
    check("rst_rvalid", 128'(bus.row_valid_o), 128'(0));
    check("rst_done",  128'(bus.done_o), 128'(0));
    check("rst_c",     128'(bus.c_o), 128'(0));
    check("rst_state", 128'(bus.state_o), 128'(2'(IDLE)));
    rst_n = 1'b1;
    tick();

    // single tile
    bus.start_i = 1'b1; bus.num_ktiles_i = 8'd1;
    tick();
    bus.start_i = 1'b0;
    check("t1_busy", 128'(bus.busy_o), 128'(1));
    check("t1_dready", 128'(bus.d_ready_o), 128'(1));
    check("t1_c0", 128'(bus.c_o), 128'(0));
    bus.d_i = tile(1, 2, 3, 4); bus.d_valid_i = 1'b1; bus.row_ready_i = 1'b1;
    tick();
    bus.d_valid_i = 1'b0;
    check("t1_r0_valid", 128'(bus.row_valid_o), 128'(1));
    check("t1_r0", 128'(bus.row_o), 128'(row2(1, 2)));
    check("t1_r0_idx", 128'(bus.row_idx_o), 128'(0));
    check("t1_c", 128'(bus.c_o), 128'(tile(1, 2, 3, 4)));
    check("t1_dready_drain", 128'(bus.d_ready_o), 128'(0));
    check("t1_done_early", 128'(bus.done_o), 128'(0));
    tick();
    check("t1_r1", 128'(bus.row_o), 128'(row2(3, 4)));
    check("t1_r1_idx", 128'(bus.row_idx_o), 128'(1));
    tick();
    check("t1_done", 128'(bus.done_o), 128'(1));
    check("t1_idle_busy", 128'(bus.busy_o), 128'(0));
    check("t1_idle_rvalid", 128'(bus.row_valid_o), 128'(0));
    tick();
    check("t1_done_once", 128'(bus.done_o), 128'(0));

    // three tiles, array model d = c + 1
    bus.start_i = 1'b1; bus.num_ktiles_i = 8'd3;
    tick();
    bus.start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t3_c%0d", k), 128'(bus.c_o), 128'(tile(k, k, k, k)));
      bus.d_i = tile(k + 1, k + 1, k + 1, k + 1); bus.d_valid_i = 1'b1;
      tick();
    end
    bus.d_valid_i = 1'b0;
    check("t3_r0", 128'(bus.row_o), 128'(row2(3, 3)));
    check("t3_r0_idx", 128'(bus.row_idx_o), 128'(0));
    tick();
    check("t3_r1", 128'(bus.row_o), 128'(row2(3, 3)));
    check("t3_r1_idx", 128'(bus.row_idx_o), 128'(1));
    tick();
    check("t3_done", 128'(bus.done_o), 128'(1));
    tick();

    // drain back-pressure; d_valid in DRAIN must not be consumed
    bus.start_i = 1'b1; bus.num_ktiles_i = 8'd1;
    tick();
    bus.start_i = 1'b0;
    bus.d_i = tile(1, 2, 3, 4); bus.d_valid_i = 1'b1; bus.row_ready_i = 1'b0;
    tick();
    bus.d_i = tile(9, 9, 9, 9);
    for (int s = 0; s < 5; s++) begin
      check($sformatf("bp_row_%0d", s), 128'(bus.row_o), 128'(row2(1, 2)));
      check($sformatf("bp_idx_%0d", s), 128'(bus.row_idx_o), 128'(0));
      check($sformatf("bp_valid_%0d", s), 128'(bus.row_valid_o), 128'(1));
      tick();
    end
    check("bp_c_hold", 128'(bus.c_o), 128'(tile(1, 2, 3, 4)));
    bus.d_valid_i = 1'b0; bus.row_ready_i = 1'b1;
    tick();
    check("bp_r1", 128'(bus.row_o), 128'(row2(3, 4)));
    check("bp_r1_idx", 128'(bus.row_idx_o), 128'(1));
    tick();
    check("bp_done", 128'(bus.done_o), 128'(1));
    tick();

    // num_ktiles = 0 runs one tile; start in DRAIN ignored
    bus.start_i = 1'b1; bus.num_ktiles_i = 8'd0;
    tick();
    bus.start_i = 1'b0;
    bus.d_i = tile(5, 6, 7, 8); bus.d_valid_i = 1'b1; bus.row_ready_i = 1'b0;
    tick();
    bus.d_valid_i = 1'b0;
    check("k0_state", 128'(bus.state_o), 128'(2'(DRAIN)));
    bus.start_i = 1'b1; bus.num_ktiles_i = 8'd3;
    tick();
    bus.start_i = 1'b0;
    check("k0_start_busy", 128'(bus.busy_o), 128'(1));
    check("k0_start_state", 128'(bus.state_o), 128'(2'(DRAIN)));
    check("k0_start_c", 128'(bus.c_o), 128'(tile(5, 6, 7, 8)));
    bus.row_ready_i = 1'b1;
    check("k0_r0", 128'(bus.row_o), 128'(row2(5, 6)));
    tick();
    check("k0_r1", 128'(bus.row_o), 128'(row2(7, 8)));
    tick();
    check("k0_done", 128'(bus.done_o), 128'(1));
    // start in the done cycle is accepted
    bus.start_i = 1'b1; bus.num_ktiles_i = 8'd1;
    tick();
    bus.start_i = 1'b0;
    check("dn_start_state", 128'(bus.state_o), 128'(2'(ACCUM)));
    check("dn_start_c", 128'(bus.c_o), 128'(0));

    // negative values, optional clamp, then reset mid-DRAIN
    bus.d_i = tile(-5, 7, 0, -1); bus.d_valid_i = 1'b1;
    tick();
    bus.d_valid_i = 1'b0;
`ifdef SWIRL_ACC_DRAIN_RELU_EN
    check("neg_r0", 128'(bus.row_o), 128'(row2(0, 7)));
`else
    check("neg_r0", 128'(bus.row_o), 128'(row2(-5, 7)));
`endif
    check("neg_c", 128'(bus.c_o), 128'(tile(-5, 7, 0, -1)));
    tick();
    check("neg_r1_idx", 128'(bus.row_idx_o), 128'(1));
`ifdef SWIRL_ACC_DRAIN_RELU_EN
    check("neg_r1", 128'(bus.row_o), 128'(row2(0, 0)));
`else
    check("neg_r1", 128'(bus.row_o), 128'(row2(0, -1)));
`endif
    rst_n = 1'b0;
    tick();
    check("mr_state", 128'(bus.state_o), 128'(2'(IDLE)));
    check("mr_rvalid", 128'(bus.row_valid_o), 128'(0));
    check("mr_c", 128'(bus.c_o), 128'(0));
    check("mr_done", 128'(bus.done_o), 128'(0));
    rst_n = 1'b1;
    tick();
    check("mr_done_after", 128'(bus.done_o), 128'(0));
    check("mr_busy_after", 128'(bus.busy_o), 128'(0));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
